// File: rtl/dot_accumulate_if.sv
// dot_accumulate_if: beat/result handshake bundle for dot_accumulate.
// Ports: in_valid/in_ready/mult_in upstream; out_valid/out_ready/dot_out
// downstream; dot_ovf only when DOT_SATURATE_EN is defined.
interface dot_accumulate_if #(
  parameter int Nbits = 4,
  parameter int Ndata = 3,
  parameter int Nacc  = 12
);
  logic                     in_valid;
  logic                     in_ready;
  logic [Ndata*2*Nbits-1:0] mult_in;
  logic                     out_valid;
  logic                     out_ready;
  logic [Nacc-1:0]          dot_out;
`ifdef DOT_SATURATE_EN
  logic                     dot_ovf;

  modport master (
    output in_valid, mult_in, out_ready,
    input  in_ready, out_valid, dot_out, dot_ovf
  );

  modport slave (
    input  in_valid, mult_in, out_ready,
    output in_ready, out_valid, dot_out, dot_ovf
  );
`else
  modport master (
    output in_valid, mult_in, out_ready,
    input  in_ready, out_valid, dot_out
  );

  modport slave (
    input  in_valid, mult_in, out_ready,
    output in_ready, out_valid, dot_out
  );
`endif
endinterface

// File: rtl/dot_accumulate.sv
// dot_accumulate: sums Ndata product lanes per beat and accumulates
// Nbeats beats into one registered dot-product result.
// Ports: clk, rst (async, active high), clear (sync abort), bus (slave).
// Optional: DOT_SATURATE_EN makes each step saturate and adds bus.dot_ovf.
module dot_accumulate #(
  parameter int Nbits  = 4,
  parameter int Ndata  = 3,
  parameter int Nbeats = 3,
  parameter int Nacc   = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  dot_accumulate_if.slave   bus
);

  localparam int PW = 2 * Nbits;
  localparam int CW = (Nbeats > 1) ? $clog2(Nbeats) : 1;
  localparam logic [CW-1:0] LAST = CW'(Nbeats - 1);

`ifdef DOT_SATURATE_EN
  // Wide enough that base + every lane can never wrap before the
  // saturation compare.
  localparam int SW = Nacc + PW + $clog2(Ndata + 1) + 1;
`else
  localparam int SW = Nacc;
`endif

  typedef enum logic {
    EMPTY,
    FULL
  } ostate_t;

  ostate_t         r_ost;
  ostate_t         w_ost_nxt;
  logic [CW-1:0]   r_cnt;
  logic [Nacc-1:0] r_acc;
  logic [Nacc-1:0] r_dot;

  logic [SW-1:0]   w_lanesum;
  logic [SW-1:0]   w_sum;
  logic [Nacc-1:0] w_step;
  logic            w_first;
  logic            w_last;
  logic            w_full;
  logic            w_ready;
  logic            w_beat;
  logic            w_fin;
  logic            w_take;

  always_comb begin
    w_lanesum = '0;
    for (int i = 0; i < Ndata; i++) begin
      w_lanesum = w_lanesum + SW'(bus.mult_in[i*PW +: PW]);
    end
  end

  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == LAST);
  assign w_full  = (r_ost == FULL);

  // Only the final beat must wait for the output register to drain.
  assign w_ready = !clear && !(w_full && !bus.out_ready && w_last);
  assign w_beat  = bus.in_valid && w_ready;
  assign w_fin   = w_beat && w_last;
  assign w_take  = w_full && bus.out_ready;

  assign w_sum = (w_first ? '0 : SW'(r_acc)) + w_lanesum;

`ifdef DOT_SATURATE_EN
  logic r_ovf_run;
  logic r_ovf;
  logic w_ovf;
  logic w_ovf_tot;

  assign w_ovf     = (w_sum > SW'({Nacc{1'b1}}));
  assign w_step    = w_ovf ? {Nacc{1'b1}} : w_sum[Nacc-1:0];
  assign w_ovf_tot = (!w_first && r_ovf_run) || w_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_run <= 1'b0;
    end else if (clear) begin
      r_ovf_run <= 1'b0;
    end else if (w_beat && !w_last) begin
      r_ovf_run <= w_ovf_tot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_fin) begin
      r_ovf <= w_ovf_tot;
    end
  end

  assign bus.dot_ovf = r_ovf;
`else
  assign w_step = w_sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (clear) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_beat) begin
      if (w_last) begin
        r_cnt <= '0;
      end else begin
        r_acc <= w_step;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dot <= '0;
    end else if (w_fin) begin
      r_dot <= w_step;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ost <= EMPTY;
    end else begin
      r_ost <= w_ost_nxt;
    end
  end

  // A take and a new final beat in the same cycle keeps FULL.
  always_comb begin
    w_ost_nxt = r_ost;
    unique case (r_ost)
      EMPTY: begin
        if (w_fin) begin
          w_ost_nxt = FULL;
        end
      end
      FULL: begin
        if (w_take && !w_fin) begin
          w_ost_nxt = EMPTY;
        end
      end
    endcase
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = w_full;
  assign bus.dot_out   = r_dot;

endmodule

// File: tb/tb_dot_accumulate.sv
// tb_dot_accumulate: directed vectors and corner sequences for
// dot_accumulate at Nbits=4, Ndata=3, Nbeats=3, Nacc=12.
module tb_dot_accumulate;

  logic clk = 1'b0;
  logic rst;
  logic clear;

  always #5 clk = ~clk;

  dot_accumulate_if #(.Nbits(4), .Ndata(3), .Nacc(12)) bus ();

  dot_accumulate #(
    .Nbits(4), .Ndata(3), .Nbeats(3), .Nacc(12)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .bus(bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [23:0] b0;
    logic [23:0] b1;
    logic [23:0] b2;
    int          exp;
  } vec_t;

  vec_t vt[5];

  function automatic logic [23:0] pk(int l2, int l1, int l0);
    return {l2[7:0], l1[7:0], l0[7:0]};
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d want %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [23:0] d);
    bus.in_valid = 1'b1;
    bus.mult_in  = d;
    #1;
    chk("send in_ready", int'(bus.in_ready), 1);
    tick();
  endtask

  int rs;

  initial begin
    vt[0] = '{pk(3,2,1), pk(6,5,4), pk(9,8,7), 45};
    vt[1] = '{pk(225,225,225), pk(225,225,225),
              pk(225,225,225), 2025};
    vt[2] = '{pk(0,0,0), pk(0,0,0), pk(0,0,0), 0};
    vt[3] = '{pk(30,20,10), pk(0,0,1), pk(0,0,100), 161};
    vt[4] = '{pk(255,255,255), pk(255,255,255),
              pk(255,255,255), 2295};

    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'($urandom);
    bus.mult_in   = 24'($urandom);
    bus.out_ready = 1'($urandom);
    #2;
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst dot_out", int'(bus.dot_out), 0);
    chk("rst in_ready", int'(bus.in_ready), 1);
    bus.in_valid = 1'b0;
    tick();
    tick();
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    tick();

    for (int v = 0; v < 5; v++) begin
      send(vt[v].b0);
      send(vt[v].b1);
      chk("vec early out_valid", int'(bus.out_valid), 0);
      send(vt[v].b2);
      chk("vec out_valid", int'(bus.out_valid), 1);
      chk("vec dot_out", int'(bus.dot_out), vt[v].exp);
      bus.in_valid = 1'b0;
      tick();
      chk("vec drain", int'(bus.out_valid), 0);
    end

    send(pk(3,2,1));
    send(pk(6,5,4));
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midrst out_valid", int'(bus.out_valid), 0);
    chk("midrst dot_out", int'(bus.dot_out), 0);
    rst = 1'b0;
    tick();
    send(pk(1,2,3));
    send(pk(0,0,0));
    send(pk(0,0,1));
    chk("postrst out_valid", int'(bus.out_valid), 1);
    chk("postrst dot_out", int'(bus.dot_out), 7);
    bus.in_valid = 1'b0;
    tick();

    bus.out_ready = 1'b0;
    send(pk(3,2,1));
    send(pk(6,5,4));
    send(pk(9,8,7));
    chk("bp pend valid", int'(bus.out_valid), 1);
    chk("bp pend dot", int'(bus.dot_out), 45);
    send(pk(2,2,2));
    send(pk(3,3,3));
    chk("bp hold dot", int'(bus.dot_out), 45);
    bus.in_valid = 1'b1;
    bus.mult_in  = pk(4,4,4);
    #1;
    chk("bp stall ready", int'(bus.in_ready), 0);
    tick();
    chk("bp stall valid", int'(bus.out_valid), 1);
    chk("bp stall dot", int'(bus.dot_out), 45);
    chk("bp stall ready2", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    #1;
    chk("bp release ready", int'(bus.in_ready), 1);
    tick();
    chk("bp swap valid", int'(bus.out_valid), 1);
    chk("bp swap dot", int'(bus.dot_out), 27);
    bus.in_valid = 1'b0;
    tick();
    chk("bp drain", int'(bus.out_valid), 0);

    bus.out_ready = 1'b0;
    send(pk(0,0,5));
    send(pk(0,0,5));
    send(pk(0,0,5));
    chk("clr pend dot", int'(bus.dot_out), 15);
    send(pk(1,2,3));
    send(pk(4,5,6));
    clear        = 1'b1;
    bus.in_valid = 1'b1;
    bus.mult_in  = pk(7,7,7);
    #1;
    chk("clr in_ready", int'(bus.in_ready), 0);
    tick();
    clear = 1'b0;
    chk("clr keep valid", int'(bus.out_valid), 1);
    chk("clr keep dot", int'(bus.dot_out), 15);
    send(pk(1,1,1));
    send(pk(1,1,1));
    bus.in_valid = 1'b1;
    bus.mult_in  = pk(1,1,1);
    #1;
    chk("clr stall ready", int'(bus.in_ready), 0);
    bus.out_ready = 1'b1;
    #1;
    chk("clr release", int'(bus.in_ready), 1);
    tick();
    chk("clr res valid", int'(bus.out_valid), 1);
    chk("clr res dot", int'(bus.dot_out), 9);
    bus.in_valid = 1'b0;
    tick();
    chk("clr drain", int'(bus.out_valid), 0);

    rs = 0;
    for (int k = 1; k <= 12; k++) begin
      bus.in_valid = 1'b1;
      bus.mult_in  = pk(3*k, 2*k, k);
      rs += 6 * k;
      tick();
      chk("b2b valid", int'(bus.out_valid),
          (k % 3 == 0) ? 1 : 0);
      if (k % 3 == 0) begin
        chk("b2b dot", int'(bus.dot_out), rs);
        rs = 0;
      end
    end
    bus.in_valid = 1'b0;
    tick();
    chk("b2b drain", int'(bus.out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dot_accumulate.md
Name: dot_accumulate

Overview:
- Downstream stage of the lane-parallel `multiply` block.
- Consumes its packed product vector: Ndata lanes of 2*Nbits unsigned products.
- Sums all lanes of each beat, then accumulates Nbeats beats into one dot-product result (one matrix-product element).
- Adds valid/ready handshakes on both sides; the output register holds each result until it is accepted.

Parameters:
- Nbits, 4: operand width of the upstream multiplier; each product lane is 2*Nbits wide.
- Ndata, 3: number of product lanes per beat.
- Nbeats, 3: beats accumulated per result; legal range >= 1.
- Nacc, 12: accumulator/result width; legal range >= 2*Nbits. Default is 2*Nbits + ceil(log2(Ndata*Nbeats)).

Ports:
- clk, input, 1: single clock; all state on rising edge.
- rst, input, 1: asynchronous, active-high reset.
- clear, input, 1: synchronous abort of the in-progress accumulation.
- in_valid, input, 1: mult_in holds a valid beat.
- in_ready, output, 1: the block can accept a beat this cycle.
- mult_in, input, Ndata*2*Nbits: packed products; lane i at [(i+1)*2*Nbits-1 : i*2*Nbits].
- out_valid, output, 1: dot_out holds a result.
- out_ready, input, 1: downstream accepts the result.
- dot_out, output, Nacc: unsigned dot-product result.

Behaviour:
- Arithmetic:
  - All values are unsigned.
  - lanesum = sum of the Ndata lanes, zero-extended to Nacc bits (combinational).
  - Without the optional feature, overflow wraps modulo 2^Nacc.
- Internal state:
  - beat_cnt, range 0..Nbeats-1: 0 = IDLE; otherwise ACCUM.
  - acc, Nacc bits.
  - Output register dot_out/out_valid: EMPTY or FULL.
- Handshakes:
  - A beat is accepted when in_valid && in_ready.
  - A result is taken when out_valid && out_ready.
  - in_ready = !clear && !(out_valid && !out_ready && beat_cnt == Nbeats-1).
  - Consequence: non-final beats are accepted while a result is pending. Only the final beat stalls on backpressure.
- Accepted beat with beat_cnt < Nbeats-1:
  - acc <= (beat_cnt == 0 ? 0 : acc) + lanesum.
  - beat_cnt increments.
- Accepted beat with beat_cnt == Nbeats-1:
  - dot_out <= (beat_cnt == 0 ? 0 : acc) + lanesum.
  - out_valid <= 1; beat_cnt <= 0.
  - If Nbeats = 1, every beat is final.
- Latency: out_valid rises on the edge that accepts the final beat. The result is visible the cycle after that beat is presented.
- Throughput: one beat per cycle, and one result per Nbeats cycles, while out_ready stays high.
- Output register:
  - out_valid clears on a taken result, unless a final beat is accepted in the same cycle. In that case the new result is loaded and out_valid stays 1.
  - dot_out is stable while out_valid && !out_ready.
- clear:
  - Forces beat_cnt <= 0 and acc <= 0.
  - in_ready is 0 while clear is high, so any beat presented that cycle is not accepted.
  - The output register and a pending result are unaffected.
- Reset, asynchronous and taking effect immediately, mid-operation included:
  - beat_cnt = 0, acc = 0, out_valid = 0, dot_out = 0.
  - Hence in_ready = 1 (when clear is low).
- in_valid low: no state change apart from output-side handshaking.

Optional Feature:
- Macro: DOT_SATURATE_EN.
- Defined:
  - Each accumulate step saturates at 2^Nacc-1 instead of wrapping.
  - Adds output port dot_ovf, 1 bit. It is registered with dot_out and is 1 if any step of that result saturated.
  - dot_ovf resets to 0 and is cleared by clear for the accumulation in progress.
- Undefined: wrap-around arithmetic and no dot_ovf port.

Test Plan (Nbits=4, Ndata=3, Nbeats=3, Nacc=12):
- Reset: rst=1 with random inputs -> out_valid=0, dot_out=0, in_ready=1. Assert rst mid-accumulation after 2 beats, then 3 fresh beats -> result contains only the fresh beats.
- Basic: beats {lane2,lane1,lane0} = {3,2,1}, {6,5,4}, {9,8,7} on consecutive cycles, out_ready=1 -> out_valid pulses the cycle after beat 3 with dot_out=45; in_ready stays 1.
- Max values: 3 beats, all lanes 225 -> dot_out=2025, no wrap. With DOT_SATURATE_EN and Nacc=10 -> dot_out=1023, dot_ovf=1.
- Backpressure: result pending with out_ready=0, next set streaming -> beats 1 and 2 accepted, beat 3 held with in_ready=0. Raise out_ready -> old result taken the same cycle beat 3 is accepted; the next result follows with out_valid continuously 1.
- clear: beats summing 6 and 15, then clear=1 for one cycle, then 3 beats of {1,1,1} -> dot_out=9. A result already pending during clear is delivered unchanged.
- Back-to-back: 4 results with out_ready=1 and continuous valid beats -> out_valid high every 3rd cycle, all sums correct, no beat lost.
